// File: rtl/ring_buf_push_arbiter_pkg.sv
// Shared state encoding, constants and one-hot/binary helpers for ring_buf_push_arbiter.
// Define ARB_RETRY_LIMIT_EN to build the bounded-retry (drop) logic.
package ring_buf_push_arbiter_pkg;

  localparam int LEN_ARB_STATE = 2;
  localparam int N_UART_REQ    = 4;
`ifdef ARB_RETRY_LIMIT_EN
  localparam int LEN_ARB_RETRY = 8;
`endif

  typedef enum logic [LEN_ARB_STATE-1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  // Helpers are sized for the largest supported requester count (16).
  function automatic logic [3:0] onehot_to_binary(input logic [15:0] i_onehot);
    logic [3:0] bin;
    bin = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_onehot[i]) begin
        bin = bin | 4'(i);
      end
    end
    return bin;
  endfunction

  function automatic logic [15:0] binary_to_onehot(input logic [3:0] i_bin);
    return 16'(1) << i_bin;
  endfunction

endpackage

// File: rtl/ring_buf_push_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first valid requester at or after i_rr_ptr, wrapping.
module rr_priority_select
  import ring_buf_push_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LEN_REQ_ID = 2
) (
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [LEN_REQ_ID-1:0] i_rr_ptr,
  output logic [N_REQ-1:0]      o_win_onehot,
  output logic [LEN_REQ_ID-1:0] o_win_id,
  output logic                  o_any
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_upper;
  logic [N_REQ-1:0] w_pick;
  logic [15:0]      w_pick_ext;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign w_mask[gi] = (gi >= int'(i_rr_ptr));
  end

  // Requests at/above the pointer take precedence; otherwise wrap to the bottom.
  assign w_upper      = i_req_valid & w_mask;
  assign w_pick       = (|w_upper) ? w_upper : i_req_valid;
  assign o_win_onehot = w_pick & (-w_pick);
  assign w_pick_ext   = 16'(o_win_onehot);
  assign o_win_id     = LEN_REQ_ID'(onehot_to_binary(w_pick_ext));
  assign o_any        = |i_req_valid;

endmodule

// File: rtl/ring_buf_push_arbiter.sv
// Round-robin arbiter sharing one ring_buf write port among N_REQ byte producers.
// Define ARB_RETRY_LIMIT_EN to drop a byte after RETRY_MAX refused pushes.
module ring_buf_push_arbiter
  import ring_buf_push_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_UART_REQ,
  parameter int LEN_REQ_ID = 2,
  parameter int RETRY_MAX  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_grant,
  output logic [N_REQ-1:0]   req_drop,
  output logic               buf_order,
  output logic [7:0]         buf_data,
  input  logic               buf_done,
  output logic               busy
);

  if (N_REQ < 2 || N_REQ > 16 || (2 ** LEN_REQ_ID) < N_REQ ||
      RETRY_MAX < 1 || RETRY_MAX > 255) begin : g_bad_cfg
    $error("ring_buf_push_arbiter: illegal parameter combination");
  end

  arb_state_t              r_state, w_state_next;
  logic [LEN_REQ_ID-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [LEN_REQ_ID-1:0]   r_win_id, w_win_id_next;
  logic [7:0]              r_buf_data, w_buf_data_next;
  logic                    r_buf_order, w_buf_order_next;
  logic [N_REQ-1:0]        r_grant;
  logic                    r_busy;
  logic                    w_grant_fire;

  logic [N_REQ-1:0]        w_sel_onehot;
  logic [LEN_REQ_ID-1:0]   w_sel_id;
  logic                    w_any;
  logic [7:0]              w_sel_byte;
  logic [7:0]              w_masked_byte [N_REQ];
  logic [LEN_REQ_ID-1:0]   w_ptr_after_win;
  logic [N_REQ-1:0]        w_win_onehot;

  rr_priority_select #(
    .N_REQ      (N_REQ),
    .LEN_REQ_ID (LEN_REQ_ID)
  ) u_select (
    .i_req_valid  (req_valid),
    .i_rr_ptr     (r_rr_ptr),
    .o_win_onehot (w_sel_onehot),
    .o_win_id     (w_sel_id),
    .o_any        (w_any)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte_mux
    assign w_masked_byte[gi] = w_sel_onehot[gi] ? req_data[gi*8 +: 8] : 8'h00;
  end

  always_comb begin
    w_sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_byte = w_sel_byte | w_masked_byte[i];
    end
  end

  assign w_ptr_after_win = (r_win_id == LEN_REQ_ID'(N_REQ - 1)) ? '0
                                                                 : r_win_id + LEN_REQ_ID'(1);
  assign w_win_onehot    = N_REQ'(binary_to_onehot(4'(r_win_id)));

`ifdef ARB_RETRY_LIMIT_EN
  localparam logic [LEN_ARB_RETRY-1:0] RETRY_LIMIT = LEN_ARB_RETRY'(RETRY_MAX);

  logic [LEN_ARB_RETRY-1:0] r_retry_cnt, w_retry_cnt_next;
  logic [N_REQ-1:0]         r_drop;
  logic                     w_at_limit;
  logic                     w_drop_fire;

  assign w_at_limit = (r_retry_cnt == RETRY_LIMIT);
`endif

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_win_id_next    = r_win_id;
    w_buf_data_next  = r_buf_data;
    w_buf_order_next = 1'b0;
    w_grant_fire     = 1'b0;
`ifdef ARB_RETRY_LIMIT_EN
    w_drop_fire      = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_win_id_next    = w_sel_id;
          w_buf_data_next  = w_sel_byte;
          w_buf_order_next = 1'b1;
          w_state_next     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        w_state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (buf_done) begin
          w_grant_fire  = 1'b1;
          w_rr_ptr_next = w_ptr_after_win;
          w_state_next  = ARB_IDLE;
        end
`ifdef ARB_RETRY_LIMIT_EN
        else if (w_at_limit) begin
          w_drop_fire   = 1'b1;
          w_rr_ptr_next = w_ptr_after_win;
          w_state_next  = ARB_IDLE;
        end
`endif
        else begin
          // Buffer was full: re-issue the same latched byte for the same winner.
          w_buf_order_next = 1'b1;
          w_state_next     = ARB_ISSUE;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_win_id    <= '0;
      r_buf_data  <= 8'h00;
      r_buf_order <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_win_id    <= w_win_id_next;
      r_buf_data  <= w_buf_data_next;
      r_buf_order <= w_buf_order_next;
      r_grant     <= w_grant_fire ? w_win_onehot : '0;
      r_busy      <= (w_state_next != ARB_IDLE);
    end
  end

`ifdef ARB_RETRY_LIMIT_EN
  always_comb begin
    w_retry_cnt_next = r_retry_cnt;
    if (r_state == ARB_WAIT) begin
      if (buf_done || w_at_limit) begin
        w_retry_cnt_next = '0;
      end else begin
        w_retry_cnt_next = r_retry_cnt + LEN_ARB_RETRY'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry_cnt <= '0;
      r_drop      <= '0;
    end else begin
      r_retry_cnt <= w_retry_cnt_next;
      r_drop      <= w_drop_fire ? w_win_onehot : '0;
    end
  end

  assign req_drop = r_drop;
`else
  assign req_drop = '0;
`endif

  assign req_grant = r_grant;
  assign buf_order = r_buf_order;
  assign buf_data  = r_buf_data;
  assign busy      = r_busy;

endmodule
